// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg : shared widths, opcode constants and fetch FSM state type.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

    localparam int ARQ_DEF    = 16;
    localparam int ADDR_W_DEF = 13;

    localparam logic [2:0] OP_SET = 3'b000;
    localparam logic [2:0] OP_JEQ = 3'b101;
    localparam logic [2:0] OP_J   = 3'b110;
    localparam logic [2:0] OP_ADD = 3'b111;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    localparam logic [15:0] BUBBLE = 16'h0000;

endpackage

`default_nettype wire

// File: rtl/instr_fetch_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_if : synchronous instruction-memory read bus (1-cycle latency).
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface instr_fetch_if
    import fetch_pkg::*;
#(
    parameter int ARQ    = ARQ_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [ARQ-1:0]    imem_rdata;

    modport master (output imem_en, output imem_addr, input  imem_rdata);
    modport slave  (input  imem_en, input  imem_addr, output imem_rdata);
endinterface

`default_nettype wire

// File: rtl/fetch_skid_buf.sv
// ---------------------------------------------------------------------------
// fetch_skid_buf : one-entry {instr, pc} holding buffer for stalled responses.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_skid_buf #(
    parameter int ARQ    = 16,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              unload,
    input  logic              flush,
    input  logic [ARQ-1:0]    in_instr,
    input  logic [ADDR_W-1:0] in_pc,
    output logic              full,
    output logic [ARQ-1:0]    out_instr,
    output logic [ADDR_W-1:0] out_pc
);

    // A simultaneous load and unload replaces the entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full      <= 1'b0;
            out_instr <= '0;
            out_pc    <= '0;
        end else if (flush) begin
            full <= 1'b0;
        end else if (load) begin
            full      <= 1'b1;
            out_instr <= in_instr;
            out_pc    <= in_pc;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch : PC owner and fetch stage with stall, redirect and skid buffer.
// Optional perf counters enabled by macro FETCH_PERF_EN.    Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module instr_fetch
    import fetch_pkg::*;
#(
    parameter int ARQ    = ARQ_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    instr_fetch_if.master     imem,
    output logic [ARQ-1:0]    instr_out,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc_out,
    output logic [15:0]       fetch_count,
    output logic [15:0]       stall_count
);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic              r_pend;
    logic [ADDR_W-1:0] r_pend_addr;
    logic              w_issue;
    logic [ADDR_W-1:0] w_issue_addr;
    logic              w_deliver;
    logic [ARQ-1:0]    w_dlv_instr;
    logic [ADDR_W-1:0] w_dlv_pc;
    logic              w_skid_full;
    logic              w_skid_load;
    logic              w_skid_unload;
    logic [ARQ-1:0]    w_skid_instr;
    logic [ADDR_W-1:0] w_skid_pc;

    always_comb begin
        w_state_nxt  = r_state;
        w_issue      = 1'b0;
        w_issue_addr = r_pc;
        case (r_state)
            BOOT:    w_state_nxt = RUN;
            RUN:     if (stall)  w_state_nxt = HOLD;
            HOLD:    if (!stall) w_state_nxt = RUN;
            default: w_state_nxt = BOOT;
        endcase
        if (redirect) begin
            w_state_nxt  = RUN;
            w_issue      = 1'b1;
            w_issue_addr = redirect_addr;
        end else if (r_state != BOOT && !stall) begin
            w_issue = 1'b1;
        end
    end

    // Skid entry is older than any pending response, so it always goes first.
    assign w_skid_load   = !redirect && r_pend && (stall || w_skid_full);
    assign w_skid_unload = !redirect && !stall && w_skid_full;
    assign w_deliver     = !redirect && !stall && (w_skid_full || r_pend);
    assign w_dlv_instr   = w_skid_full ? w_skid_instr : imem.imem_rdata;
    assign w_dlv_pc      = w_skid_full ? w_skid_pc    : r_pend_addr;

    assign imem.imem_en   = w_issue;
    assign imem.imem_addr = w_issue_addr;

    fetch_skid_buf #(
        .ARQ    (ARQ),
        .ADDR_W (ADDR_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (w_skid_load),
        .unload    (w_skid_unload),
        .flush     (redirect),
        .in_instr  (imem.imem_rdata),
        .in_pc     (r_pend_addr),
        .full      (w_skid_full),
        .out_instr (w_skid_instr),
        .out_pc    (w_skid_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= BOOT;
            r_pc        <= '0;
            r_pend      <= 1'b0;
            r_pend_addr <= '0;
            instr_out   <= ARQ'(BUBBLE);
            instr_valid <= 1'b0;
            pc_out      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pend      <= w_issue;
            r_pend_addr <= w_issue_addr;
            if (w_issue) begin
                r_pc <= w_issue_addr + ADDR_W'(1);
            end
            if (!stall) begin
                instr_valid <= w_deliver;
                if (w_deliver) begin
                    instr_out <= w_dlv_instr;
                    pc_out    <= w_dlv_pc;
                end
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [15:0] r_fetch_cnt;
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_deliver && r_fetch_cnt != 16'hFFFF) begin
                r_fetch_cnt <= r_fetch_cnt + 16'd1;
            end
            if (stall && r_stall_cnt != 16'hFFFF) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign fetch_count = r_fetch_cnt;
    assign stall_count = r_stall_cnt;
`else
    assign fetch_count = 16'h0000;
    assign stall_count = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch : scoreboard bench for instr_fetch against a stream model.
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_instr_fetch;

    localparam int ARQ    = 16;
    localparam int ADDR_W = 13;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              stall = 1'b0;
    logic              redirect = 1'b0;
    logic [ADDR_W-1:0] redirect_addr = '0;
    logic [ARQ-1:0]    instr_out;
    logic              instr_valid;
    logic [ADDR_W-1:0] pc_out;
    logic [15:0]       fetch_count;
    logic [15:0]       stall_count;

    instr_fetch_if #(.ARQ(ARQ), .ADDR_W(ADDR_W)) imem ();

    instr_fetch #(.ARQ(ARQ), .ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .imem          (imem),
        .instr_out     (instr_out),
        .instr_valid   (instr_valid),
        .pc_out        (pc_out),
        .fetch_count   (fetch_count),
        .stall_count   (stall_count)
    );

    always #5 clk = ~clk;

    logic [ARQ-1:0] mem [DEPTH];

    always @(posedge clk) begin
        if (imem.imem_en) imem.imem_rdata <= mem[imem.imem_addr];
    end

    typedef struct {
        logic              valid;
        logic [ADDR_W-1:0] pc;
        logic [ARQ-1:0]    instr;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: the fetch stream as a queue of requested-but-undelivered addresses.
    bit                m_run;
    logic [ADDR_W-1:0] m_pc;
    logic [ADDR_W-1:0] m_fly[$];
    exp_t              m_out;
    int                m_fetch;
    int                m_stall;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0;
        m_pc  = '0;
        m_fly.delete();
        m_out = '{valid: 1'b0, pc: '0, instr: '0};
        m_fetch = 0;
        m_stall = 0;
        sb.delete();
    endtask

    task automatic model_step(input bit st, input bit rd, input logic [ADDR_W-1:0] ra);
        logic [ADDR_W-1:0] a;
        if (st && m_stall < 65535) m_stall++;
        if (rd) begin
            m_fly.delete();
            m_fly.push_back(ra);
            m_pc = ra + ADDR_W'(1);
            if (!st) m_out.valid = 1'b0;
        end else if (!st) begin
            if (m_fly.size() > 0) begin
                a = m_fly.pop_front();
                m_out = '{valid: 1'b1, pc: a, instr: mem[a]};
                if (m_fetch < 65535) m_fetch++;
            end else begin
                m_out.valid = 1'b0;
            end
            if (m_run) begin
                m_fly.push_back(m_pc);
                m_pc = m_pc + ADDR_W'(1);
            end
        end
        m_run = 1'b1;
        sb.push_back(m_out);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic cycle(input bit st, input bit rd, input logic [ADDR_W-1:0] ra);
        stall         = st;
        redirect      = rd;
        redirect_addr = ra;
        #1;
        if (rd) begin
            check("imem_en_redir", 32'(imem.imem_en), 32'd1);
            check("imem_addr_redir", 32'(imem.imem_addr), 32'(ra));
        end else if (m_run && !st) begin
            check("imem_en_issue", 32'(imem.imem_en), 32'd1);
            check("imem_addr_issue", 32'(imem.imem_addr), 32'(m_pc));
        end else begin
            check("imem_en_idle", 32'(imem.imem_en), 32'd0);
        end
        @(posedge clk);
        model_step(st, rd, ra);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        stall    = 1'b0;
        redirect = 1'b0;
        #1;
        model_reset();
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr_out", 32'(instr_out), 32'd0);
        check("rst_pc_out", 32'(pc_out), 32'd0);
        check("rst_imem_en", 32'(imem.imem_en), 32'd0);
        check("rst_fetch_count", 32'(fetch_count), 32'd0);
        check("rst_stall_count", 32'(stall_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_counters();
`ifdef FETCH_PERF_EN
        check("fetch_count", 32'(fetch_count), 32'(m_fetch));
        check("stall_count", 32'(stall_count), 32'(m_stall));
`else
        check("fetch_count", 32'(fetch_count), 32'd0);
        check("stall_count", 32'(stall_count), 32'd0);
`endif
    endtask

    exp_t mon_e;

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check("instr_valid", 32'(instr_valid), 32'(mon_e.valid));
            if (mon_e.valid) begin
                check("pc_out", 32'(pc_out), 32'(mon_e.pc));
                check("instr_out", 32'(instr_out), 32'(mon_e.instr));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = ARQ'($urandom);
        model_reset();
        @(negedge clk);
        do_reset();

        // Cold start, then a 3-cycle stall with an in-flight response.
        repeat (4) cycle(1'b0, 1'b0, '0);
        repeat (3) cycle(1'b1, 1'b0, '0);
        repeat (3) cycle(1'b0, 1'b0, '0);

        // Plain redirect.
        cycle(1'b0, 1'b1, 13'h0100);
        repeat (3) cycle(1'b0, 1'b0, '0);

        // Redirect together with stall, stall held one more cycle.
        cycle(1'b1, 1'b1, 13'h0040);
        cycle(1'b1, 1'b0, '0);
        repeat (3) cycle(1'b0, 1'b0, '0);

        // Address wrap at the top of memory.
        cycle(1'b0, 1'b1, 13'd8190);
        repeat (5) cycle(1'b0, 1'b0, '0);

        // Back-to-back redirects.
        cycle(1'b0, 1'b1, 13'h0200);
        cycle(1'b0, 1'b1, 13'h0300);
        repeat (3) cycle(1'b0, 1'b0, '0);

        // Counter run: 10 deliveries and 4 stall cycles.
        do_reset();
        repeat (5) cycle(1'b0, 1'b0, '0);
        repeat (4) cycle(1'b1, 1'b0, '0);
        repeat (7) cycle(1'b0, 1'b0, '0);
        check("model_fetch_total", 32'(m_fetch), 32'd10);
        check_counters();

        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            cycle(($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 5),
                  ADDR_W'($urandom));
        end
        check_counters();

        // Reset in the middle of activity, then restart.
        cycle(1'b1, 1'b1, 13'h0777);
        do_reset();
        repeat (6) cycle(1'b0, 1'b0, '0);
        check_counters();

        @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
